// File: rtl/cond_logic_if.sv
// Decoder/FSM <-> condition stage signal bundle for the multicycle ARM core.
// master = decoder/FSM side, slave = cond_logic.
interface cond_logic_if;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;
   logic       CondEx;

   modport master (
      output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite,
      input  PCWrite, RegWrite, MemWrite, Flags, CondEx
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite,
      output PCWrite, RegWrite, MemWrite, Flags, CondEx
   );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation and write-strobe gating for the multicycle ARM core.
// Define COND_PERF_CNT_EN to add the InstrCount/SquashCount performance counters.
module cond_logic #(
   parameter logic [3:0] FLAGS_RST = 4'b0000
`ifdef COND_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic         clk,
   input logic         reset,
   cond_logic_if.slave bus
`ifdef COND_PERF_CNT_EN
   , output logic [CNT_W-1:0] InstrCount,
   output logic [CNT_W-1:0]   SquashCount
`endif
);

   logic [3:0] flags_reg;
   logic [3:0] flags_next;
   logic       condex_q_reg;
   logic       cond_ex;
   logic [1:0] flag_write;
   logic       n_flag;
   logic       z_flag;
   logic       c_flag;
   logic       v_flag;

   assign n_flag = flags_reg[3];
   assign z_flag = flags_reg[2];
   assign c_flag = flags_reg[1];
   assign v_flag = flags_reg[0];

   always_comb begin
      cond_ex = 1'b0;
      case (bus.Cond)
         4'b0000: cond_ex = z_flag;
         4'b0001: cond_ex = ~z_flag;
         4'b0010: cond_ex = c_flag;
         4'b0011: cond_ex = ~c_flag;
         4'b0100: cond_ex = n_flag;
         4'b0101: cond_ex = ~n_flag;
         4'b0110: cond_ex = v_flag;
         4'b0111: cond_ex = ~v_flag;
         4'b1000: cond_ex = c_flag & ~z_flag;
         4'b1001: cond_ex = ~c_flag | z_flag;
         4'b1010: cond_ex = (n_flag == v_flag);
         4'b1011: cond_ex = (n_flag != v_flag);
         4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
         4'b1101: cond_ex = z_flag | (n_flag != v_flag);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Fetch cycles never update flags, so an unknown Cond during fetch cannot reach the register.
   assign flag_write = bus.FlagW & {2{cond_ex & ~bus.IRWrite}};

   // Pair gi=1 holds {N,Z}, pair gi=0 holds {C,V}; each has its own write enable.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_flag_pair
         assign flags_next[2*gi +: 2] = flag_write[gi] ? bus.ALUFlags[2*gi +: 2]
                                                       : flags_reg[2*gi +: 2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_reg    <= FLAGS_RST;
         condex_q_reg <= 1'b0;
      end else begin
         flags_reg    <= flags_next;
         condex_q_reg <= cond_ex;
      end
   end

   // Gating uses the condition from the previous cycle, i.e. before this instruction's flag update.
   assign bus.PCWrite  = (bus.PCS & condex_q_reg) | bus.NextPC;
   assign bus.RegWrite = bus.RegW & condex_q_reg;
   assign bus.MemWrite = bus.MemW & condex_q_reg;
   assign bus.Flags    = flags_reg;
   assign bus.CondEx   = cond_ex;

`ifdef COND_PERF_CNT_EN
   logic             irq_dec_reg;
   logic [CNT_W-1:0] instr_count_reg;
   logic [CNT_W-1:0] squash_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_dec_reg      <= 1'b0;
         instr_count_reg  <= '0;
         squash_count_reg <= '0;
      end else begin
         irq_dec_reg <= bus.IRWrite;
         if (bus.IRWrite)
            instr_count_reg <= instr_count_reg + CNT_W'(1);
         if (irq_dec_reg && !cond_ex)
            squash_count_reg <= squash_count_reg + CNT_W'(1);
      end
   end

   assign InstrCount  = instr_count_reg;
   assign SquashCount = squash_count_reg;
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed plus randomized bench for cond_logic against a flag-level reference model.
module tb_cond_logic;

   localparam logic [3:0] FLAGS_RST = 4'b0000;
`ifdef COND_PERF_CNT_EN
   localparam int CNT_W = 4;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   // reference model state
   logic [3:0] m_flags;
   logic       m_condq;
`ifdef COND_PERF_CNT_EN
   logic [CNT_W-1:0] InstrCount;
   logic [CNT_W-1:0] SquashCount;
   int               m_instr;
   int               m_squash;
   logic             m_dec;
`endif

   cond_logic_if bus ();

`ifdef COND_PERF_CNT_EN
   cond_logic #(.FLAGS_RST(FLAGS_RST), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .InstrCount  (InstrCount),
      .SquashCount (SquashCount)
   );
`else
   cond_logic #(.FLAGS_RST(FLAGS_RST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ARM condition from its mnemonic meaning: odd codes below 14 are the negation of the even one.
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      if (c == 4'd15) return 1'b0;
      if (c == 4'd14) return 1'b1;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         default: base = !z && (n == v);
      endcase
      return base ^ c[0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic npc,
                        input logic rw, input logic mw, input logic irw);
      reset        = rst;
      bus.Cond     = c;
      bus.ALUFlags = af;
      bus.FlagW    = fw;
      bus.PCS      = pcs;
      bus.NextPC   = npc;
      bus.RegW     = rw;
      bus.MemW     = mw;
      bus.IRWrite  = irw;
      #1;
   endtask

   task automatic check_all(input string tag);
      logic ce;
      ce = cond_true(bus.Cond, m_flags);
      check({tag, ".Flags"},    {28'd0, bus.Flags}, {28'd0, m_flags});
      check({tag, ".CondEx"},   {31'd0, bus.CondEx}, {31'd0, ce});
      check({tag, ".PCWrite"},  {31'd0, bus.PCWrite}, {31'd0, (bus.PCS & m_condq) | bus.NextPC});
      check({tag, ".RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, bus.RegW & m_condq});
      check({tag, ".MemWrite"}, {31'd0, bus.MemWrite}, {31'd0, bus.MemW & m_condq});
`ifdef COND_PERF_CNT_EN
      check({tag, ".InstrCount"},  {28'd0, InstrCount},  32'(m_instr % 16));
      check({tag, ".SquashCount"}, {28'd0, SquashCount}, 32'(m_squash % 16));
`endif
   endtask

   // Advance one clock and update the model from the inputs held across the edge.
   task automatic tick();
      logic ce;
      ce = cond_true(bus.Cond, m_flags);
      @(posedge clk);
      if (reset) begin
         m_flags = FLAGS_RST;
         m_condq = 1'b0;
`ifdef COND_PERF_CNT_EN
         m_instr = 0; m_squash = 0; m_dec = 1'b0;
`endif
      end else begin
         if (bus.FlagW[1] && ce) m_flags[3:2] = bus.ALUFlags[3:2];
         if (bus.FlagW[0] && ce) m_flags[1:0] = bus.ALUFlags[1:0];
         m_condq = ce;
`ifdef COND_PERF_CNT_EN
         if (m_dec && !ce) m_squash++;
         if (bus.IRWrite) m_instr++;
         m_dec = bus.IRWrite;
`endif
      end
      #1;
   endtask

   initial begin
      logic [3:0] exp_ge [4];
      logic       rst_r;
      logic       irw_r;
      logic [1:0] fw_r;
      n_vec = 0;
      n_err = 0;
      m_flags = 4'bxxxx;
      m_condq = 1'bx;
`ifdef COND_PERF_CNT_EN
      m_instr = 0; m_squash = 0; m_dec = 1'b0;
`endif

      // 1: reset for two cycles with raw strobes high
      drive(1, 4'he, 4'h0, 2'b00, 0, 1, 1, 1, 0);
      tick();
      tick();
      check_all("rst");
      check("rst.Flags_const", {28'd0, bus.Flags}, 32'h0);
      check("rst.PCWrite_const", {31'd0, bus.PCWrite}, 32'd1);
      check("rst.RegWrite_const", {31'd0, bus.RegWrite}, 32'd0);
      check("rst.MemWrite_const", {31'd0, bus.MemWrite}, 32'd0);

      // 2: AL flag write, then EQ true, then gated register write
      drive(0, 4'he, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
      check_all("t2a");
      tick();
      drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      check_all("t2b");
      check("t2.Flags_const", {28'd0, bus.Flags}, 32'h4);
      check("t2.CondEx_const", {31'd0, bus.CondEx}, 32'd1);
      tick();
      drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
      check_all("t2c");
      check("t2.RegWrite_const", {31'd0, bus.RegWrite}, 32'd1);
      tick();

      // 3: NE false with Z set squashes all gated writes
      drive(0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      tick();
      drive(0, 4'h1, 4'h0, 2'b00, 1, 0, 1, 1, 0);
      check_all("t3");
      check("t3.gated_const", {29'd0, bus.RegWrite, bus.MemWrite, bus.PCWrite}, 32'd0);
      tick();

      // 4: N=1,V=1 sweep of GE/LT/GT/LE and never
      drive(0, 4'he, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
      tick();
      exp_ge[0] = 4'd1; exp_ge[1] = 4'd0; exp_ge[2] = 4'd1; exp_ge[3] = 4'd0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'(10 + i), 4'h0, 2'b00, 0, 0, 0, 0, 0);
         check_all("t4");
         check("t4.CondEx_const", {31'd0, bus.CondEx}, {28'd0, exp_ge[i]});
      end
      drive(0, 4'hf, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      check("t4.never_const", {31'd0, bus.CondEx}, 32'd0);
      tick();

      // 5: failed condition blocks flag write; AL lets it through
      drive(0, 4'he, 4'h0, 2'b11, 0, 0, 0, 0, 0);
      tick();
      drive(0, 4'h0, 4'hf, 2'b11, 0, 0, 0, 0, 0);
      check_all("t5a");
      tick();
      drive(0, 4'he, 4'hf, 2'b11, 0, 0, 0, 0, 0);
      check_all("t5b");
      check("t5.hold_const", {28'd0, bus.Flags}, 32'h0);
      tick();
      drive(0, 4'he, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      check_all("t5c");
      check("t5.load_const", {28'd0, bus.Flags}, 32'hf);
      tick();

`ifdef COND_PERF_CNT_EN
      // 6: 16 fetch/decode pairs, three decodes with Cond=1111
      drive(1, 4'he, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(0, 4'he, 4'h0, 2'b00, 0, 1, 0, 0, 1);
         tick();
         drive(0, (i % 5 == 1) ? 4'hf : 4'he, 4'h0, 2'b00, 0, 0, 0, 0, 0);
         tick();
      end
      drive(0, 4'he, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      check("t6.InstrCount_const", {28'd0, InstrCount}, 32'd0);
      check("t6.SquashCount_const", {28'd0, SquashCount}, 32'd3);
      tick();
`endif

      // random traffic; flags are never written during fetch
      for (int i = 0; i < 400; i++) begin
         rst_r = ($urandom_range(0, 24) == 0);
         irw_r = ($urandom_range(0, 3) == 0);
         fw_r  = irw_r ? 2'b00 : 2'($urandom_range(0, 3));
         drive(rst_r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), fw_r,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), irw_r);
         check_all("rand");
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
